// File: rtl/elevator_pkg.sv
// Shared encodings for the six-stop elevator: directions, controller states, stop one-hots.
// Stop order from bit 0 upward: 1, 2, 2W, 3, 3W, 4.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 6;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } state_t;

  localparam logic [NUM_FLOORS_DEF-1:0] FLOOR_1  = 6'b000001;
  localparam logic [NUM_FLOORS_DEF-1:0] FLOOR_2  = 6'b000010;
  localparam logic [NUM_FLOORS_DEF-1:0] FLOOR_2W = 6'b000100;
  localparam logic [NUM_FLOORS_DEF-1:0] FLOOR_3  = 6'b001000;
  localparam logic [NUM_FLOORS_DEF-1:0] FLOOR_3W = 6'b010000;
  localparam logic [NUM_FLOORS_DEF-1:0] FLOOR_4  = 6'b100000;

endpackage

// File: rtl/elevator_timer.sv
// Terminal-count timer: counts 0..CYCLES-1 while enabled, wraps to 0 and pulses o_done on the last count.
// Clear has priority over enable; no backpressure.
module elevator_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign o_done = i_en & ~i_clr & w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// SCAN elevator car controller: latches calls, times travel and door dwell, drives registered floor/direction.
// Calls act one cycle after they appear; all outputs registered, no backpressure.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [NUM_FLOORS-1:0] floor,
  output logic [1:0]            direction,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] calls_pending
);

  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

  state_t                r_state;
  logic [NUM_FLOORS-1:0] r_floor;
  logic [1:0]            r_dir;
  logic                  r_door;
  logic [NUM_FLOORS-1:0] r_pending;

  state_t                w_state_nxt;
  logic [NUM_FLOORS-1:0] w_floor_nxt;
  logic [1:0]            w_dir_nxt;
  logic [NUM_FLOORS-1:0] w_pending_nxt;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [NUM_FLOORS-1:0] w_discard;
  logic [NUM_FLOORS-1:0] w_above;
  logic [NUM_FLOORS-1:0] w_below;
  logic [NUM_FLOORS-1:0] w_step;
  logic                  w_restart;
  logic                  w_moving;
  logic                  w_in_door;
  logic                  w_dwell_clr;
  logic                  w_travel_done;
  logic                  w_dwell_done;

  assign w_moving    = (r_state == MOVING);
  assign w_in_door   = (r_state == DOOR);
  assign w_dwell_clr = ~w_in_door | w_restart;

  // Only the bits strictly above / below the car count as "ahead" for SCAN.
  assign w_above = r_pending & ~((r_floor << 1) - ONE);
  assign w_below = r_pending & (r_floor - ONE);
  assign w_step  = (r_dir == DIR_UP) ? (r_floor << 1) : (r_floor >> 1);

  elevator_timer #(.CYCLES(TRAVEL_CYCLES)) u_travel (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (~w_moving),
    .i_en    (w_moving),
    .o_done  (w_travel_done)
  );

  elevator_timer #(.CYCLES(DOOR_CYCLES)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_dwell_clr),
    .i_en    (w_in_door),
    .o_done  (w_dwell_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_dir_nxt   = r_dir;
    w_clr       = '0;
    w_discard   = '0;
    w_restart   = 1'b0;
    case (r_state)
      IDLE: begin
        w_dir_nxt = DIR_IDLE;
        if (|(r_pending & r_floor)) begin
          w_state_nxt = DOOR;
          w_clr       = r_floor;
        end else if (|w_above) begin
          w_state_nxt = MOVING;
          w_dir_nxt   = DIR_UP;
        end else if (|w_below) begin
          w_state_nxt = MOVING;
          w_dir_nxt   = DIR_DOWN;
        end
      end
      MOVING: begin
        if (w_travel_done) begin
          w_floor_nxt = w_step;
          if (|(r_pending & w_step)) begin
            w_state_nxt = DOOR;
            w_clr       = w_step;
          end
        end
      end
      DOOR: begin
        w_discard = r_floor;
        // A fresh call for this stop holds the door rather than queueing a revisit.
        if (|(call_req & r_floor)) begin
          w_restart = 1'b1;
        end else if (w_dwell_done) begin
          if ((r_dir == DIR_UP) && (|w_above)) begin
            w_state_nxt = MOVING;
          end else if ((r_dir == DIR_DOWN) && (|w_below)) begin
            w_state_nxt = MOVING;
          end else if (|w_above) begin
            w_state_nxt = MOVING;
            w_dir_nxt   = DIR_UP;
          end else if (|w_below) begin
            w_state_nxt = MOVING;
            w_dir_nxt   = DIR_DOWN;
          end else begin
            w_state_nxt = IDLE;
            w_dir_nxt   = DIR_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_dir_nxt   = DIR_IDLE;
      end
    endcase
    w_pending_nxt = (r_pending | (call_req & ~w_discard)) & ~w_clr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_floor   <= ONE;
      r_dir     <= DIR_IDLE;
      r_door    <= 1'b0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_floor   <= w_floor_nxt;
      r_dir     <= w_dir_nxt;
      r_door    <= (w_state_nxt == DOOR);
      r_pending <= w_pending_nxt;
    end
  end

  assign floor         = r_floor;
  assign direction     = r_dir;
  assign door_open     = r_door;
  assign calls_pending = r_pending;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] call_req;
  logic [5:0] floor;
  logic [1:0] direction;
  logic       door_open;
  logic [5:0] calls_pending;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c0;

  typedef struct {
    string      tag;
    int         cyc;
    logic [5:0] floor;
    logic [1:0] dir;
    logic       door;
    logic [5:0] pend;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  elevator_controller #(
    .NUM_FLOORS    (6),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .call_req      (call_req),
    .floor         (floor),
    .direction     (direction),
    .door_open     (door_open),
    .calls_pending (calls_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int c, input logic [5:0] f,
                      input logic [1:0] d, input logic dr, input logic [5:0] p);
    exp_t x;
    x.tag = tag; x.cyc = c; x.floor = f; x.dir = d; x.door = dr; x.pend = p;
    sb.push_back(x);
  endtask

  function automatic logic [5:0] up_floor(input int k);
    logic [5:0] b;
    b = 6'b000001;
    return b << ((k - 2) / 4);
  endfunction

  function automatic logic [5:0] dn_floor(input int k);
    logic [5:0] t;
    t = 6'b100000;
    return t >> ((k - 25) / 4);
  endfunction

  // Outputs sampled on the falling edge; entries are due when the cycle count reaches them.
  always @(negedge clk) begin
    if (reset_n) chk("onehot_floor", 32'($onehot(floor)), 32'd1);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("%s.floor@%0d", e.tag, e.cyc), 32'(floor), 32'(e.floor));
      chk($sformatf("%s.dir@%0d", e.tag, e.cyc), 32'(direction), 32'(e.dir));
      chk($sformatf("%s.door@%0d", e.tag, e.cyc), 32'(door_open), 32'(e.door));
      chk($sformatf("%s.pend@%0d", e.tag, e.cyc), 32'(calls_pending), 32'(e.pend));
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    call_req = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    c0 = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic pulse(input logic [5:0] v, input int at);
    wait_cyc(at);
    call_req = v;
    wait_cyc(at + 1);
    call_req = 6'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    call_req = 6'b0;

    // Idle after reset with no calls.
    do_reset();
    for (int k = 0; k <= 20; k++) push("idle", c0 + k, 6'b000001, 2'b00, 1'b0, 6'b0);
    drain();

    // Call at the current stop: door opens from IDLE with direction idle.
    do_reset();
    push("here", c0, 6'b000001, 2'b00, 1'b0, 6'b0);
    push("here", c0 + 1, 6'b000001, 2'b00, 1'b0, 6'b000001);
    for (int k = 2; k <= 4; k++) push("here", c0 + k, 6'b000001, 2'b00, 1'b1, 6'b0);
    for (int k = 5; k <= 7; k++) push("here", c0 + k, 6'b000001, 2'b00, 1'b0, 6'b0);
    pulse(6'b000001, c0);
    drain();

    // Full run to the top stop.
    do_reset();
    push("top", c0, 6'b000001, 2'b00, 1'b0, 6'b0);
    push("top", c0 + 1, 6'b000001, 2'b00, 1'b0, 6'b100000);
    for (int k = 2; k <= 21; k++) push("top", c0 + k, up_floor(k), 2'b10, 1'b0, 6'b100000);
    for (int k = 22; k <= 24; k++) push("top", c0 + k, 6'b100000, 2'b10, 1'b1, 6'b0);
    for (int k = 25; k <= 26; k++) push("top", c0 + k, 6'b100000, 2'b00, 1'b0, 6'b0);
    pulse(6'b100000, c0);
    drain();

    // Call behind the car while moving up: finish upward, then reverse.
    do_reset();
    push("scan", c0 + 1, 6'b000001, 2'b00, 1'b0, 6'b100000);
    for (int k = 2; k <= 7; k++) push("scan", c0 + k, up_floor(k), 2'b10, 1'b0, 6'b100000);
    for (int k = 8; k <= 21; k++) push("scan", c0 + k, up_floor(k), 2'b10, 1'b0, 6'b100001);
    for (int k = 22; k <= 24; k++) push("scan", c0 + k, 6'b100000, 2'b10, 1'b1, 6'b000001);
    for (int k = 25; k <= 44; k++) push("scan", c0 + k, dn_floor(k), 2'b01, 1'b0, 6'b000001);
    for (int k = 45; k <= 47; k++) push("scan", c0 + k, 6'b000001, 2'b01, 1'b1, 6'b0);
    for (int k = 48; k <= 49; k++) push("scan", c0 + k, 6'b000001, 2'b00, 1'b0, 6'b0);
    pulse(6'b100000, c0);
    pulse(6'b000001, c0 + 7);
    drain();

    // Same-stop call on the last dwell count holds the door for a full dwell.
    do_reset();
    push("hold", c0 + 1, 6'b000001, 2'b00, 1'b0, 6'b001000);
    for (int k = 2; k <= 13; k++) push("hold", c0 + k, up_floor(k), 2'b10, 1'b0, 6'b001000);
    for (int k = 14; k <= 19; k++) push("hold", c0 + k, 6'b001000, 2'b10, 1'b1, 6'b0);
    for (int k = 20; k <= 21; k++) push("hold", c0 + k, 6'b001000, 2'b00, 1'b0, 6'b0);
    pulse(6'b001000, c0);
    pulse(6'b001000, c0 + 16);
    drain();

    // New call for the arrival stop on the arrival edge: door opens once.
    do_reset();
    push("arrive", c0 + 1, 6'b000001, 2'b00, 1'b0, 6'b000100);
    for (int k = 2; k <= 9; k++) push("arrive", c0 + k, up_floor(k), 2'b10, 1'b0, 6'b000100);
    for (int k = 10; k <= 12; k++) push("arrive", c0 + k, 6'b000100, 2'b10, 1'b1, 6'b0);
    for (int k = 13; k <= 16; k++) push("arrive", c0 + k, 6'b000100, 2'b00, 1'b0, 6'b0);
    pulse(6'b000100, c0);
    pulse(6'b000100, c0 + 9);
    drain();

    // Reset mid-travel takes effect without a clock edge.
    do_reset();
    push("rst", c0 + 1, 6'b000001, 2'b00, 1'b0, 6'b100000);
    for (int k = 2; k <= 11; k++) push("rst", c0 + k, up_floor(k), 2'b10, 1'b0, 6'b100000);
    pulse(6'b100000, c0);
    wait_cyc(c0 + 12);
    chk("rst_pre_floor", 32'(floor), 32'(6'b000100));
    reset_n = 1'b0;
    #2;
    chk("rst_async_floor", 32'(floor), 32'(6'b000001));
    chk("rst_async_dir", 32'(direction), 32'd0);
    chk("rst_async_door", 32'(door_open), 32'd0);
    chk("rst_async_pend", 32'(calls_pending), 32'd0);
    chk("rst_sb_empty", 32'(sb.size()), 32'd0);
    wait_cyc(c0 + 15);
    reset_n = 1'b1;
    c0 = cyc;
    for (int k = 0; k <= 5; k++) push("post_rst", c0 + k, 6'b000001, 2'b00, 1'b0, 6'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Sequential elevator car controller for a six-stop shaft.
- Latches hall/car call requests and schedules service in SCAN order (keep going while calls lie ahead, then reverse).
- Times floor-to-floor travel and door dwell.
- Produces the one-hot floor and 2-bit direction consumed by the floor display block, so it is the producer end of that floor/direction interface.

Parameters:
- NUM_FLOORS, 6, number of stops; floor vector width (stop order, bit 0 to 5: 1, 2, 2W, 3, 3W, 4).
- TRAVEL_CYCLES, 50_000_000, clock cycles to move one stop.
- DOOR_CYCLES, 100_000_000, clock cycles the door stays open at a serviced stop.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- call_req  input  NUM_FLOORS  call request per stop, level or pulse; sampled every cycle.
- floor  output  NUM_FLOORS  one-hot current stop.
- direction  output  2  2'b10 up, 2'b01 down, 2'b00 idle.
- door_open  output  1  high while the door dwells at a stop.
- calls_pending  output  NUM_FLOORS  latched unserviced calls.

Behaviour:
- Reset (async assert, sync release):
  - floor=6'b000001, direction=2'b00, door_open=0, calls_pending=0.
  - State IDLE, both timers 0.
  - Reset mid-travel or mid-dwell abandons the operation immediately.
- Call latch: pending |= call_req each cycle, except:
  - a bit is cleared on the edge where the car arrives at that stop and enters DOOR;
  - a call for the current stop while in DOOR is discarded, and the dwell timer restarts at 0 (door held).
- Masks: above = pending & ~((floor<<1)-1); below = pending & (floor-1).
- States: IDLE, MOVING, DOOR.
- IDLE:
  - pending bit at current floor: next cycle DOOR, door_open=1, bit cleared, direction stays 00.
  - else above≠0: MOVING with direction=10.
  - else below≠0: MOVING with direction=01.
  - else stay IDLE.
  - Decision uses the pending value registered at the start of the cycle, so a call is acted on one cycle after it appears on call_req.
- MOVING:
  - Travel counter counts 0..TRAVEL_CYCLES-1.
  - On the terminal count, floor shifts one position (left if up, right if down) and the counter clears.
  - If the new stop is pending: enter DOOR on that same edge, clear the bit, door_open=1.
  - Otherwise keep moving in the same direction.
  - Never shifts past bit 0 or bit NUM_FLOORS-1. This is guaranteed by the scheduling rule; also assert it in the bench.
- DOOR:
  - Dwell counter counts 0..DOOR_CYCLES-1; on the terminal count door_open drops and the next state is chosen by SCAN:
  - dir up and above≠0: MOVING up.
  - dir down and below≠0: MOVING down.
  - else above≠0: MOVING up.
  - else below≠0: MOVING down.
  - else IDLE with direction=00.
  - direction holds its last travel value during DOOR. It is 00 only when the door was opened from IDLE.
- Simultaneous calls: all set bits latch in one cycle. Ordering is purely SCAN; there is no per-request priority.
- Arrival at a stop with a new call arriving the same cycle for that stop: the arrival clear wins and the door opens once.
- All outputs are registered; no combinational path from call_req to outputs.

Decomposition:
- elevator_pkg holds:
  - NUM_FLOORS default;
  - direction encoding constants DIR_IDLE=2'b00, DIR_UP=2'b10, DIR_DOWN=2'b01;
  - state enum {IDLE, MOVING, DOOR};
  - one-hot stop constants FLOOR_1 … FLOOR_4.
- One sub-module, elevator_timer: parameterised terminal-count counter with clear/enable inputs and a done pulse. It is instantiated twice (travel, dwell).
- The call latch and SCAN logic stay in the top.

Test Plan (bench overrides TRAVEL_CYCLES=4, DOOR_CYCLES=3):
- Reset, then no calls for 20 cycles -> floor=000001, direction=00, door_open=0, calls_pending=000000 throughout.
- From reset, call_req=000001 for 1 cycle -> door_open=1 from cycle 2 for 3 cycles, direction=00, floor unchanged, then IDLE.
- From reset, call_req=100000 pulse -> direction=10 next cycle.
  - floor steps 000010, 000100, 001000, 010000, 100000 every 4 cycles.
  - door_open=1 for 3 cycles at 100000, then direction=00 and calls_pending=0.
- Car moving up at 000010 with pending 100000; inject call_req=000001 -> car continues up, services 100000, then direction=01 and travels down to 000001.
- Car in DOOR at 001000; assert call_req=001000 on dwell count 2 -> dwell restarts, door_open stays high 3 more cycles, calls_pending bit 3 stays 0.
- Assert reset_n=0 mid-travel between 000100 and 001000 -> outputs return to reset values immediately, without waiting for a clock edge; after release the car is idle at 000001.
